// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle for the 7-segment scan controller: packed digit data in,
// multiplexed anode/cathode drive and frame strobe out.
interface seven_seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                lzb;
  logic [DIGITS-1:0]   an_n;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic                frame_done;

  modport master (
    output value, dp, digit_en, lzb,
    input  an_n, seg_n, dp_n, frame_done
  );

  modport slave (
    input  value, dp, digit_en, lzb,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent input capture
// and leading-zero blanking; all display outputs are registered.
module seven_seg_scan_ctrl #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     sv_q, sv_d;
  logic [DIGITS-1:0] sdp_q, sdp_d;
  logic [DIGITS-1:0] sen_q, sen_d;
  logic              slzb_q, slzb_d;
  logic              pending_q;
  logic              frame_done_q, frame_done_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick, last, boundary, capture, blank, lz_blank;
  logic [VW-1:0]     shifted;
  logic [3:0]        nib;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    g = 7'b1111111;
    case (h)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_comb begin
    tick     = (cnt_q == CW'(TICK_DIV - 1));
    last     = (idx_q == IW'(DIGITS - 1));
    boundary = tick & last;
    capture  = pending_q | boundary;

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + 1'b1;

    sv_d   = sv_q;
    sdp_d  = sdp_q;
    sen_d  = sen_q;
    slzb_d = slzb_q;
    if (capture) begin
      sv_d   = bus.value;
      sdp_d  = bus.dp;
      sen_d  = bus.digit_en;
      slzb_d = bus.lzb;
    end
    // The post-reset capture is silent; only true frame boundaries strobe.
    frame_done_d = boundary;

    // Nibbles at and above idx; all-zero means this digit is a leading zero.
    shifted  = sv_q >> {idx_q, 2'b00};
    nib      = shifted[3:0];
    lz_blank = slzb_q && (idx_q != '0) && (shifted == '0);
    blank    = !sen_q[idx_q] || lz_blank;

    an_d  = blank ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d = blank ? 7'b1111111 : glyph(nib);
    dp_d  = blank | ~sdp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sv_q         <= '0;
      sdp_q        <= '0;
      sen_q        <= '0;
      slzb_q       <= 1'b0;
      pending_q    <= 1'b1;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sv_q         <= sv_d;
      sdp_q        <= sdp_d;
      sen_q        <= sen_d;
      slzb_q       <= slzb_d;
      pending_q    <= 1'b0;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an_n       = an_q;
  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: hand sequences, a vector table and
// randomized traffic checked against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;
  localparam int D = 4;
  localparam int T = 4;
  localparam int F = D * T;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  seven_seg_scan_ctrl_if #(.DIGITS(D)) bus ();

  seven_seg_scan_ctrl #(
    .DIGITS  (D),
    .TICK_DIV(T)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: n counts edges since reset release (-1 while in reset).
  int         n = -1;
  logic [15:0] m_v;
  logic [3:0]  m_dp, m_en;
  logic        m_lzb;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn, e_fd;
  logic [6:0]  glyph_tab [16];

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic             lzb;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpn;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      n = -1;
      m_v = '0; m_dp = '0; m_en = '0; m_lzb = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
    end else begin
      n++;
      if (n == 0) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
      end else begin
        int d;
        logic [15:0] up;
        logic blk;
        d   = (n / T) % D;
        up  = m_v >> (4 * d);
        blk = !m_en[d] || (m_lzb && d != 0 && up == 16'h0);
        if (blk) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
        end else begin
          e_an  = ~(4'b0001 << d);
          e_seg = glyph_tab[up[3:0]];
          e_dpn = ~m_dp[d];
        end
      end
      e_fd = ((n + 1) % F) == 0;
      if (n == 0 || e_fd) begin
        m_v = bus.value; m_dp = bus.dp; m_en = bus.digit_en; m_lzb = bus.lzb;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("mdl_an", 16'(bus.an_n), 16'(e_an));
    check("mdl_seg", 16'(bus.seg_n), 16'(e_seg));
    check("mdl_dp", 16'(bus.dp_n), 16'(e_dpn));
    check("mdl_fd", 16'(bus.frame_done), 16'(e_fd));
  endtask

  task automatic run_to(input int k);
    while (n < k) step();
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg);
    check({tag, "_an"}, 16'(bus.an_n), 16'(an));
    check({tag, "_seg"}, 16'(bus.seg_n), 16'(seg));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    // an/seg listed digit 3 .. digit 0
    vecs[0] = '{16'h0050, 4'b0000, 4'b1111, 1'b1,
                {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1111};
    vecs[1] = '{16'h0000, 4'b0000, 4'b1111, 1'b1,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
    vecs[2] = '{16'h1234, 4'b0110, 4'b1011, 1'b0,
                {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1001111, 7'b1111111, 7'b0000110, 7'b1001100}, 4'b1101};
    vecs[3] = '{16'hF0E9, 4'b1001, 4'b1111, 1'b1,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0111000, 7'b0000001, 7'b0110000, 7'b0000100}, 4'b0110};
    vecs[4] = '{16'h8076, 4'b1111, 4'b0000, 1'b0,
                {4'b1111, 4'b1111, 4'b1111, 4'b1111},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1111};
    vecs[5] = '{16'h0A00, 4'b0100, 4'b1111, 1'b1,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111111, 7'b0001000, 7'b0000001, 7'b0000001}, 4'b1011};

    bus.value = '0; bus.dp = '0; bus.digit_en = '0; bus.lzb = 1'b0;
    reset_n = 1'b0;

    // Reset and release
    repeat (3) step();
    chk_out("rst", 4'b1111, 7'b1111111);
    check("rst_dp", 16'(bus.dp_n), 16'h1);
    check("rst_fd", 16'(bus.frame_done), 16'h0);
    bus.value = 16'h1234; bus.digit_en = 4'b1111;
    reset_n = 1'b1;
    step();
    chk_out("rel0", 4'b1111, 7'b1111111);
    check("rel0_fd", 16'(bus.frame_done), 16'h0);
    step();
    chk_out("rel1", 4'b1110, 7'b1001100);

    // Scan order and dwell
    run_to(3);  chk_out("s3", 4'b1110, 7'b1001100);
    run_to(4);  chk_out("s4", 4'b1101, 7'b0000110);
    run_to(7);  chk_out("s7", 4'b1101, 7'b0000110);
    run_to(8);  chk_out("s8", 4'b1011, 7'b0010010);
    run_to(13); chk_out("s13", 4'b0111, 7'b1001111);
    run_to(14); check("s14_fd", 16'(bus.frame_done), 16'h0);
    run_to(15); check("s15_fd", 16'(bus.frame_done), 16'h1);
    run_to(16); check("s16_fd", 16'(bus.frame_done), 16'h0);
    chk_out("s16", 4'b1110, 7'b1001100);

    // Frame-coherent capture: change while idx = 1
    run_to(20);
    bus.value = 16'hABCD;
    run_to(25); chk_out("c25", 4'b1011, 7'b0010010);
    run_to(29); chk_out("c29", 4'b0111, 7'b1001111);
    run_to(33); chk_out("c33", 4'b1110, 7'b1000010);
    run_to(37); chk_out("c37", 4'b1101, 7'b0110001);
    run_to(41); chk_out("c41", 4'b1011, 7'b1100000);
    run_to(45); chk_out("c45", 4'b0111, 7'b0001000);

    // Vector table, one frame per record
    for (int r = 0; r < 6; r++) begin
      int i;
      int base;
      bus.value = vecs[r].value; bus.dp = vecs[r].dp;
      bus.digit_en = vecs[r].en; bus.lzb = vecs[r].lzb;
      i = 0;
      do begin
        step();
        i++;
      end while (bus.frame_done !== 1'b1 && i < 2 * F);
      check($sformatf("v%0d_fdwait", r), 16'(bus.frame_done), 16'h1);
      base = n;
      for (int d = 0; d < D; d++) begin
        run_to(base + 2 + T * d);
        check($sformatf("v%0d_an%0d", r, d), 16'(bus.an_n), 16'(vecs[r].an[d]));
        check($sformatf("v%0d_seg%0d", r, d), 16'(bus.seg_n), 16'(vecs[r].seg[d]));
        check($sformatf("v%0d_dp%0d", r, d), 16'(bus.dp_n), 16'(vecs[r].dpn[d]));
      end
    end

    // Mid-frame reset at cnt = 2, idx = 2
    while (((n + 1) % F) != 10) step();
    reset_n = 1'b0;
    step();
    chk_out("mr", 4'b1111, 7'b1111111);
    check("mr_dp", 16'(bus.dp_n), 16'h1);
    check("mr_fd", 16'(bus.frame_done), 16'h0);
    reset_n = 1'b1;
    bus.value = 16'h5A3C; bus.digit_en = 4'b1111; bus.lzb = 1'b0; bus.dp = 4'b0001;
    step();
    chk_out("mr0", 4'b1111, 7'b1111111);
    step();
    chk_out("mr1", 4'b1110, 7'b0110001);
    check("mr1_dp", 16'(bus.dp_n), 16'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(7) == 0) begin
        bus.value = 16'($urandom);
        if ($urandom_range(1) == 1) bus.value = bus.value & (16'hFFFF >> (4 * $urandom_range(3)));
        bus.dp = 4'($urandom);
        bus.digit_en = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
        bus.lzb = 1'($urandom);
      end
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(199) == 0) reset_n = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
